// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared phase encoding and default timing for the alarm annunciator
package alarm_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_ENTRY    = 2'd1,
    PH_SOUNDING = 2'd2,
    PH_LOCKOUT  = 2'd3
  } phase_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_ENTRY_TICKS = 10;
  localparam int DEF_SIREN_TICKS = 60;

endpackage

// File: rtl/alarm_tick_counter.sv
// rtl/alarm_tick_counter.sv - loadable tick-qualified down-counter with is_one flag
module alarm_tick_counter
  import alarm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             is_one_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      // Guarded so a stray decrement can never wrap the counter.
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/alarm_annunciator.sv
// rtl/alarm_annunciator.sv - entry-delay, siren and lockout sequencing for the alarm outputs
module alarm_annunciator
  import alarm_pkg::*;
#(
  parameter int ENTRY_TICKS = DEF_ENTRY_TICKS,
  parameter int SIREN_TICKS = DEF_SIREN_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             alarm_state_i,
  input  logic             disarm_i,
  output logic             siren_o,
  output logic             chime_o,
  output logic             tripped_o,
  output logic [1:0]       phase_o,
  output logic [CNT_W-1:0] countdown_o
);

  phase_e           state_q;
  logic             siren_q;
  logic             chime_q;
  logic             tripped_q;
  logic             alarm_prev_q;
  logic             alarm_rise;

  logic             cnt_clr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_is_one;

  assign alarm_rise = alarm_state_i & ~alarm_prev_q;

  // Counter control mirrors the FSM's transition priority so the two never disagree.
  always_comb begin
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (disarm_i) begin
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        PH_IDLE: begin
          if (alarm_state_i) begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(ENTRY_TICKS);
          end
        end
        PH_ENTRY: begin
          if (tick_i) begin
            if (cnt_is_one) begin
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(SIREN_TICKS);
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        PH_SOUNDING: begin
          if (tick_i) begin
            if (cnt_is_one) begin
              cnt_clr = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        PH_LOCKOUT: begin
          if (alarm_rise) begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(SIREN_TICKS);
          end
        end
        default: begin
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  alarm_tick_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt_value),
    .is_one_o   (cnt_is_one)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= PH_IDLE;
      siren_q      <= 1'b0;
      chime_q      <= 1'b0;
      tripped_q    <= 1'b0;
      alarm_prev_q <= 1'b0;
    end else begin
      alarm_prev_q <= alarm_state_i;
      if (disarm_i) begin
        state_q   <= PH_IDLE;
        siren_q   <= 1'b0;
        chime_q   <= 1'b0;
        tripped_q <= 1'b0;
      end else begin
        case (state_q)
          PH_IDLE: begin
            if (alarm_state_i) begin
              state_q <= PH_ENTRY;
              chime_q <= 1'b1;
            end
          end
          PH_ENTRY: begin
            if (tick_i) begin
              if (cnt_is_one) begin
                state_q   <= PH_SOUNDING;
                siren_q   <= 1'b1;
                tripped_q <= 1'b1;
                chime_q   <= 1'b0;
              end else begin
                chime_q <= ~chime_q;
              end
            end
          end
          PH_SOUNDING: begin
            if (tick_i && cnt_is_one) begin
              state_q <= PH_LOCKOUT;
              siren_q <= 1'b0;
            end
          end
          PH_LOCKOUT: begin
            // Only a fresh opening re-sounds; a sensor left open stays quiet.
            if (alarm_rise) begin
              state_q <= PH_SOUNDING;
              siren_q <= 1'b1;
            end
          end
          default: begin
            state_q <= PH_IDLE;
            siren_q <= 1'b0;
            chime_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign siren_o     = siren_q;
  assign chime_o     = chime_q;
  assign tripped_o   = tripped_q;
  assign phase_o     = state_q;
  assign countdown_o = cnt_value;

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb/tb_alarm_annunciator.sv - directed self-checking bench for alarm_annunciator
module tb_alarm_annunciator;

  logic       clk_i;
  logic       rst_i;
  logic       tick_i;
  logic       alarm_state_i;
  logic       disarm_i;
  logic       siren_o;
  logic       chime_o;
  logic       tripped_o;
  logic [1:0] phase_o;
  logic [7:0] countdown_o;

  int n_cmp;
  int n_bad;

  alarm_annunciator #(
    .ENTRY_TICKS(3),
    .SIREN_TICKS(4),
    .CNT_W      (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tick_i       (tick_i),
    .alarm_state_i(alarm_state_i),
    .disarm_i     (disarm_i),
    .siren_o      (siren_o),
    .chime_o      (chime_o),
    .tripped_o    (tripped_o),
    .phase_o      (phase_o),
    .countdown_o  (countdown_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Present inputs for one rising edge, then sample 1 time unit after it.
  task automatic drive(input logic t, input logic a, input logic d);
    tick_i        = t;
    alarm_state_i = a;
    disarm_i      = d;
    @(posedge clk_i);
    #1;
    tick_i   = 1'b0;
    disarm_i = 1'b0;
  endtask

  // Observed vector layout: {phase, countdown, siren, chime, tripped}
  task automatic test_reset;
    rst_i = 1'b1; tick_i = 1'b0; alarm_state_i = 1'b0; disarm_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== {2'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset_state got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, 13'h0);
    end
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== {2'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL idle_tick_ignored got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, 13'h0);
    end
  endtask

  task automatic test_entry;
    logic [12:0] exp_v [5];
    exp_v[0] = {2'd1, 8'd3, 1'b0, 1'b1, 1'b0};
    exp_v[1] = {2'd1, 8'd2, 1'b0, 1'b0, 1'b0};
    exp_v[2] = {2'd1, 8'd2, 1'b0, 1'b0, 1'b0};
    exp_v[3] = {2'd1, 8'd1, 1'b0, 1'b1, 1'b0};
    exp_v[4] = {2'd2, 8'd4, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b0, 1'b1, 1'b0);
        2:       drive(1'b0, 1'b0, 1'b0);
        default: drive(1'b1, 1'b0, 1'b0);
      endcase
      n_cmp++;
      if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== exp_v[i]) begin
        n_bad++; $display("FAIL entry_step%0d got=%h want=%h", i, {phase_o, countdown_o, siren_o, chime_o, tripped_o}, exp_v[i]);
      end
    end
  endtask

  task automatic test_sounding_lockout;
    logic [12:0] exp_v [4];
    exp_v[0] = {2'd2, 8'd3, 1'b1, 1'b0, 1'b1};
    exp_v[1] = {2'd2, 8'd2, 1'b1, 1'b0, 1'b1};
    exp_v[2] = {2'd2, 8'd1, 1'b1, 1'b0, 1'b1};
    exp_v[3] = {2'd3, 8'd0, 1'b0, 1'b0, 1'b1};
    // Alarm rises during SOUNDING (ignored) and stays high into LOCKOUT.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== exp_v[i]) begin
        n_bad++; $display("FAIL sounding_step%0d got=%h want=%h", i, {phase_o, countdown_o, siren_o, chime_o, tripped_o}, exp_v[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 1'b1, 1'b0);
    end
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== exp_v[3]) begin
      n_bad++; $display("FAIL lockout_steady_high got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, exp_v[3]);
    end
  endtask

  task automatic test_lockout_retrigger;
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== {2'd3, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL lockout_low got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, {2'd3, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== {2'd2, 8'd4, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL lockout_retrigger got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, {2'd2, 8'd4, 1'b1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o} !== {2'd2, 8'd3, 1'b1}) begin
      n_bad++; $display("FAIL pre_reset_sounding got=%h want=%h", {phase_o, countdown_o, siren_o}, {2'd2, 8'd3, 1'b1});
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== 13'h0) begin
      n_bad++; $display("FAIL async_reset_immediate got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, 13'h0);
    end
    alarm_state_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== 13'h0) begin
      n_bad++; $display("FAIL after_reset_release got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, 13'h0);
    end
  endtask

  task automatic test_disarm_priority;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({phase_o, countdown_o, chime_o} !== {2'd1, 8'd1, 1'b1}) begin
      n_bad++; $display("FAIL entry_at_one got=%h want=%h", {phase_o, countdown_o, chime_o}, {2'd1, 8'd1, 1'b1});
    end
    drive(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== 13'h0) begin
      n_bad++; $display("FAIL disarm_over_tick got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, 13'h0);
    end
    drive(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== 13'h0) begin
      n_bad++; $display("FAIL disarm_over_alarm got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, 13'h0);
    end
    alarm_state_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [12:0] exp_v [4];
    exp_v[0] = {2'd1, 8'd3, 1'b0, 1'b1, 1'b0};
    exp_v[1] = {2'd1, 8'd2, 1'b0, 1'b0, 1'b0};
    exp_v[2] = {2'd1, 8'd1, 1'b0, 1'b1, 1'b0};
    exp_v[3] = {2'd2, 8'd4, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), 1'b0);
      n_cmp++;
      if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== exp_v[i]) begin
        n_bad++; $display("FAIL b2b_step%0d got=%h want=%h", i, {phase_o, countdown_o, siren_o, chime_o, tripped_o}, exp_v[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({phase_o, countdown_o, siren_o, chime_o, tripped_o} !== 13'h0) begin
      n_bad++; $display("FAIL disarm_sounding got=%h want=%h", {phase_o, countdown_o, siren_o, chime_o, tripped_o}, 13'h0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_entry();
    test_sounding_lockout();
    test_lockout_retrigger();
    test_async_reset();
    test_disarm_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_annunciator.md
Name: alarm_annunciator

Overview:
Consumer end of the alarm-state signal: takes the combined, enable-gated alarm level from the sensor logic and drives the user-facing outputs.
- Runs an entry-delay countdown with a chime, then sounds the siren for a bounded time.
- After the siren times out, holds a latched "tripped" indication until the keypad disarms.
- Sits between the sensor/enable combiner and the siren/LED drivers; timing comes from a shared 1 Hz tick strobe.

Parameters:
ENTRY_TICKS, 10, ticks from trigger to siren (legal range 1..2^CNT_W-1)
SIREN_TICKS, 60, ticks the siren sounds before auto-silence (legal range 1..2^CNT_W-1)
CNT_W, 8, countdown counter width

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Tick  input  1  single-cycle timebase strobe (nominally 1 Hz)
Alarm_State  input  1  HIGH when any enabled sensor is open
Disarm  input  1  single-cycle keypad disarm pulse
Siren  output  1  HIGH while siren sounds
Chime  output  1  entry-delay beeper; toggles on each counted Tick in ENTRY
Tripped  output  1  latched: an alarm reached SOUNDING since the last disarm
Phase  output  2  current state encoding
Countdown  output  CNT_W  remaining ticks in ENTRY/SOUNDING; 0 otherwise

Behaviour:
- One clock, Clock. Reset is asynchronous and active-high.
- All outputs are registered.
- Reset state: Phase=IDLE, Siren=0, Chime=0, Tripped=0, Countdown=0, edge-detect register=0.
- Reset asserted mid-operation aborts immediately to the reset state, including mid-SOUNDING.
- State encoding: IDLE=0, ENTRY=1, SOUNDING=2, LOCKOUT=3.
- Edge detect: a registered copy of Alarm_State; rise = Alarm_State & ~prev.
- Priority, highest first: Reset, Disarm, timer expiry, trigger.
- Disarm in any state, on the next edge: Phase=IDLE, Siren=0, Chime=0, Tripped=0, Countdown=0.
  - Disarm wins over a simultaneous Tick or Alarm_State.
- IDLE:
  - Alarm_State high (level, not edge) -> ENTRY with Countdown=ENTRY_TICKS and Chime=1.
  - A Tick in that same cycle is not counted.
- ENTRY:
  - Each Tick decrements Countdown and toggles Chime.
  - Tick while Countdown==1 -> SOUNDING with Countdown=SIREN_TICKS, Siren=1, Tripped=1, Chime=0.
  - Alarm_State falling does NOT cancel the entry delay; the trigger is latched.
- SOUNDING:
  - Siren=1 and each Tick decrements Countdown.
  - Tick while Countdown==1 -> LOCKOUT with Siren=0, Countdown=0; Tripped stays 1.
  - Alarm_State changes are ignored.
- LOCKOUT:
  - Rising edge of Alarm_State -> SOUNDING directly (no entry delay) with Countdown=SIREN_TICKS and Siren=1.
  - A steady-high Alarm_State does not retrigger.
- Latency: one Clock from the qualifying input cycle to the output change. Countdown never wraps below 1 in the counting states.
- Tick may arrive back-to-back cycles; each strobe is counted.
- Tick is ignored in IDLE and LOCKOUT.
- ENTRY_TICKS=1: the first counted Tick enters SOUNDING.

Decomposition:
- Shared package alarm_pkg:
  - phase encoding constants (IDLE/ENTRY/SOUNDING/LOCKOUT, 2 bits);
  - default tick counts;
  - CNT_W default.
  The same package is used by the status display logic.
- One natural sub-module: alarm_tick_counter.
  - Loadable down-counter with load value, load enable, Tick-qualified decrement and an is_one flag.
  - The FSM stays in the top module.

Test Plan:
Params ENTRY_TICKS=3, SIREN_TICKS=4.
1. Reset mid-SOUNDING (async, between edges) -> all outputs 0 immediately; after release, Phase=0 and Countdown=0.
2. IDLE, Alarm_State=1 for one cycle, then 3 Ticks -> after the trigger edge Phase=1, Countdown=3, Chime=1; Countdown goes 2, 1, then Phase=2, Siren=1, Tripped=1, Countdown=4; Chime sequence 1, 0, 1 then 0.
3. Continue from scenario 2 with 4 Ticks -> Countdown 3, 2, 1, then Phase=3, Siren=0, Tripped=1; hold Alarm_State=1 for 10 cycles -> stays LOCKOUT.
4. LOCKOUT, Alarm_State 0 then 1 -> next edge Phase=2, Siren=1, Countdown=4, no ENTRY pass.
5. ENTRY with Countdown=1, Tick and Disarm in the same cycle -> Phase=0, Siren=0, Tripped=0 (Disarm wins).
6. IDLE, Alarm_State and Tick in the same cycle -> Phase=1, Countdown=3 (Tick not counted); back-to-back Ticks on the next 3 cycles -> SOUNDING after the third.
